// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin merge of ALU and LSU write FIFOs onto one registered register_file write port.
// Optional WRITEBACK_ARBITER_PENDING_QUERY_EN adds a pending-write query on any queued or in-flight destination.
module writeback_arbiter #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset_n,
   input  logic                      i_Alu_Valid,
   output logic                      o_Alu_Ready,
   input  logic [REG_ADDR_WIDTH-1:0] i_Alu_Rd,
   input  logic [XLEN-1:0]           i_Alu_Data,
   input  logic                      i_Lsu_Valid,
   output logic                      o_Lsu_Ready,
   input  logic [REG_ADDR_WIDTH-1:0] i_Lsu_Rd,
   input  logic [XLEN-1:0]           i_Lsu_Data,
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
   input  logic [REG_ADDR_WIDTH-1:0] i_Query_Rd,
   output logic                      o_Query_Pending,
`endif
   output logic                      o_Wr_En,
   output logic [REG_ADDR_WIDTH-1:0] o_Wr_Addr,
   output logic [XLEN-1:0]           o_Wr_Data,
   output logic                      o_Wr_From_Lsu
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   logic [1:0]                valid, ready, push, pop, nempty;
   logic [REG_ADDR_WIDTH-1:0] rd_in [2];
   logic [XLEN-1:0]           data_in [2];
   logic [REG_ADDR_WIDTH-1:0] mem_rd [2][FIFO_DEPTH];
   logic [XLEN-1:0]           mem_data [2][FIFO_DEPTH];
   logic [PW-1:0]             rptr [2];
   logic [PW-1:0]             wptr [2];
   logic [CW-1:0]             cnt [2];
   logic                      rr, grant_lsu, grant_valid;
   assign valid      = {i_Lsu_Valid, i_Alu_Valid};
   assign rd_in[0]   = i_Alu_Rd;
   assign rd_in[1]   = i_Lsu_Rd;
   assign data_in[0] = i_Alu_Data;
   assign data_in[1] = i_Lsu_Data;
   // ready depends on occupancy only, so a full FIFO never accepts even while being popped
   always_comb begin
      ready  = '0;
      nempty = '0;
      push   = '0;
      for (int s = 0; s < 2; s++) begin
         ready[s]  = cnt[s] != CW'(FIFO_DEPTH);
         nempty[s] = cnt[s] != '0;
         push[s]   = valid[s] & ready[s] & (rd_in[s] != '0);
      end
   end
   assign grant_lsu   = nempty[1] & (~nempty[0] | rr);
   assign grant_valid = |nempty;
   assign pop         = {nempty[1] & grant_lsu, nempty[0] & ~grant_lsu};
   assign o_Alu_Ready = ready[0];
   assign o_Lsu_Ready = ready[1];
   always_ff @(posedge i_Clock)
      for (int s = 0; s < 2; s++)
         if (push[s]) begin
            mem_rd[s][wptr[s]]   <= rd_in[s];
            mem_data[s][wptr[s]] <= data_in[s];
         end
   always_ff @(posedge i_Clock or negedge i_Reset_n)
      if (!i_Reset_n) begin
         for (int s = 0; s < 2; s++) begin
            rptr[s] <= '0;
            wptr[s] <= '0;
            cnt[s]  <= '0;
         end
         rr            <= 1'b0;
         o_Wr_En       <= 1'b0;
         o_Wr_Addr     <= '0;
         o_Wr_Data     <= '0;
         o_Wr_From_Lsu <= 1'b0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) wptr[s] <= wptr[s] + PW'(1);
            if (pop[s]) rptr[s] <= rptr[s] + PW'(1);
            cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
         end
         o_Wr_En <= grant_valid;
         if (grant_valid) begin
            rr            <= ~grant_lsu;
            o_Wr_Addr     <= grant_lsu ? mem_rd[1][rptr[1]] : mem_rd[0][rptr[0]];
            o_Wr_Data     <= grant_lsu ? mem_data[1][rptr[1]] : mem_data[0][rptr[0]];
            o_Wr_From_Lsu <= grant_lsu;
         end
      end
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
   logic [PW-1:0] off;
   // an entry is live when its distance from the read pointer is below the count
   always_comb begin
      off             = '0;
      o_Query_Pending = o_Wr_En && (o_Wr_Addr == i_Query_Rd);
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rptr[s];
            if (({1'b0, off} < cnt[s]) && (mem_rd[s][i] == i_Query_Rd)) o_Query_Pending = 1'b1;
         end
      if (i_Query_Rd == '0) o_Query_Pending = 1'b0;
   end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus against a queue-based reference of the writeback arbiter.
module tb_writeback_arbiter;
   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int D    = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic            alu_valid, lsu_valid, alu_ready, lsu_ready, wr_en, wr_from_lsu;
   logic [RW-1:0]   alu_rd, lsu_rd, wr_addr;
   logic [XLEN-1:0] alu_data, lsu_data, wr_data;
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
   logic [RW-1:0]   query_rd = '0;
   logic            query_pending;
`endif
   writeback_arbiter #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .FIFO_DEPTH(D)) dut (
      .i_Clock(clk),
      .i_Reset_n(rst_n),
      .i_Alu_Valid(alu_valid),
      .o_Alu_Ready(alu_ready),
      .i_Alu_Rd(alu_rd),
      .i_Alu_Data(alu_data),
      .i_Lsu_Valid(lsu_valid),
      .o_Lsu_Ready(lsu_ready),
      .i_Lsu_Rd(lsu_rd),
      .i_Lsu_Data(lsu_data),
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
      .i_Query_Rd(query_rd),
      .o_Query_Pending(query_pending),
`endif
      .o_Wr_En(wr_en),
      .o_Wr_Addr(wr_addr),
      .o_Wr_Data(wr_data),
      .o_Wr_From_Lsu(wr_from_lsu)
   );
   typedef struct {
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } ent_t;
   ent_t            aq[$];
   ent_t            lq[$];
   logic [XLEN-1:0] seen[$];
   bit              lsu_turn, exp_en, exp_lsu;
   logic [RW-1:0]   exp_addr;
   logic [XLEN-1:0] exp_data;
   int              checks = 0, fails = 0, wr_count = 0, alu_wr = 0, alu_acc = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      aq.delete();
      lq.delete();
      lsu_turn = 0;
      exp_en   = 0;
      exp_lsu  = 0;
      exp_addr = '0;
      exp_data = '0;
   endtask
   // one clock edge of the reference: pick per round-robin, then accept new offers
   task automatic model_edge();
      bit   a_rdy, l_rdy, take_l;
      ent_t e;
      a_rdy  = aq.size() < D;
      l_rdy  = lq.size() < D;
      exp_en = (aq.size() > 0) || (lq.size() > 0);
      if (exp_en) begin
         take_l = (lq.size() > 0) && ((aq.size() == 0) || lsu_turn);
         if (take_l) e = lq.pop_front();
         else e = aq.pop_front();
         exp_addr = e.rd;
         exp_data = e.data;
         exp_lsu  = take_l;
         lsu_turn = !take_l;
      end
      if (alu_valid && a_rdy && alu_rd != 0) begin
         aq.push_back('{alu_rd, alu_data});
         alu_acc++;
      end
      if (lsu_valid && l_rdy && lsu_rd != 0) lq.push_back('{lsu_rd, lsu_data});
   endtask
   function automatic bit exp_pending(input logic [RW-1:0] q);
      if (q == 0) return 0;
      foreach (aq[i]) if (aq[i].rd == q) return 1;
      foreach (lq[i]) if (lq[i].rd == q) return 1;
      return exp_en && exp_addr == q;
   endfunction
   task automatic check_all(input string tag);
      check({tag, ".alu_ready"}, alu_ready, aq.size() < D);
      check({tag, ".lsu_ready"}, lsu_ready, lq.size() < D);
      check({tag, ".wr_en"}, wr_en, exp_en);
      check({tag, ".wr_addr"}, wr_addr, exp_addr);
      check({tag, ".wr_data"}, wr_data, exp_data);
      check({tag, ".from_lsu"}, wr_from_lsu, exp_lsu);
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
      check({tag, ".pending"}, query_pending, exp_pending(query_rd));
`endif
      if (wr_en === 1'b1) begin
         wr_count++;
         seen.push_back(wr_data);
         if (!wr_from_lsu) alu_wr++;
      end
   endtask
   task automatic step(input string tag, input bit av, input logic [RW-1:0] ard, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [RW-1:0] lrd, input logic [XLEN-1:0] ld);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = ad;
      lsu_valid = lv;
      lsu_rd    = lrd;
      lsu_data  = ld;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, RW'($urandom), $urandom, 0, RW'($urandom), $urandom);
   endtask
   task automatic do_reset();
      alu_valid = 0;
      lsu_valid = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("reset.wr_en", wr_en, 0);
      check("reset.wr_addr", wr_addr, 0);
      check("reset.wr_data", wr_data, 0);
      check("reset.from_lsu", wr_from_lsu, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all("post_reset");
   endtask
   initial begin
      int ai, bi;
      bit saw_full;
      alu_valid = 0;
      lsu_valid = 0;
      alu_rd = '0;
      lsu_rd = '0;
      alu_data = '0;
      lsu_data = '0;
      model_reset();
      @(negedge clk);
      do_reset();
      // single ALU write: visible two cycles after acceptance, exactly once
      wr_count = 0;
      step("alu_push", 1, 5, 32'hDEADBEEF, 0, 0, 0);
      check("alu_push.no_early_write", wr_en, 0);
      step("alu_lat", 0, 0, 0, 0, 0, 0);
      check("alu_lat.en", wr_en, 1);
      check("alu_lat.addr", wr_addr, 5);
      check("alu_lat.data", wr_data, 32'hDEADBEEF);
      idle("alu_after", 3);
      check("alu_once.count", wr_count, 1);
      // x0 writes are accepted but dropped
      wr_count = 0;
      step("x0_push", 1, 0, 32'h1234, 0, 0, 0);
      idle("x0_after", 3);
      check("x0.count", wr_count, 0);
      // saturated contention: A0,B0,A1,B1,...
      do_reset();
      seen.delete();
      ai = 0;
      bi = 0;
      for (int i = 0; i < 16; i++) begin
         bit ar, br;
         ar = alu_ready;
         br = lsu_ready;
         step("rr", 1, 1, 32'hA0 + ai, 1, 2, 32'hB0 + bi);
         if (ar) ai++;
         if (br) bi++;
      end
      idle("rr_drain", 6);
      for (int k = 0; k < 8; k++)
         check($sformatf("rr.seq%0d", k), seen[k], (k % 2 == 0) ? 32'hA0 + k / 2 : 32'hB0 + k / 2);
      check("rr.total", seen.size(), ai + bi);
      // backpressure with LSU-favoured pointer
      do_reset();
      step("bp_prime", 1, 3, 32'h300, 0, 0, 0);
      alu_acc = 1;
      alu_wr = 0;
      saw_full = 0;
      for (int i = 0; i < 12; i++) begin
         if (alu_ready === 1'b0) saw_full = 1;
         step("bp", 1, RW'(4 + i), 32'h400 + i, 1, 9, 32'h900 + i);
      end
      idle("bp_drain", 8);
      check("bp.saw_full", saw_full, 1);
      check("bp.alu_conserved", alu_wr, alu_acc);
      // asynchronous reset between edges discards everything
      do_reset();
      for (int i = 0; i < 3; i++) step("ar_fill", 1, 6, 32'h60 + i, 1, 7, 32'h70 + i);
      #2 rst_n = 1'b0;
      #1;
      check("async.wr_en", wr_en, 0);
      check("async.alu_ready", alu_ready, 1);
      check("async.lsu_ready", lsu_ready, 1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      wr_count = 0;
      idle("async_after", 4);
      check("async.no_stale", wr_count, 0);
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
      query_rd = 7;
      step("q_push", 0, 0, 0, 1, 7, 32'h77);
      check("q.pending_queued", query_pending, 1);
      idle("q_drain", 3);
      check("q.pending_cleared", query_pending, 0);
      query_rd = 0;
      step("q_zero", 1, 0, 32'h5, 1, 7, 32'h8);
      check("q.zero", query_pending, 0);
`endif
      // random traffic, including x0 and garbage on idle inputs
      for (int i = 0; i < 400; i++) begin
`ifdef WRITEBACK_ARBITER_PENDING_QUERY_EN
         query_rd = RW'($urandom_range(0, 7));
`endif
         step("rand", $urandom_range(0, 9) < 7, RW'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 6, RW'($urandom_range(0, 7)), $urandom);
      end
      idle("rand_drain", 6);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single register_file write port between two producers: the arithmetic_logic_unit result path (ALU source) and the load path (LSU source).
- Each source has a small in-order FIFO with a valid/ready handshake.
- A round-robin arbiter drains the two FIFOs into a registered write port that drives register_file directly, one write per cycle.

Parameters:
- XLEN, 32, data width of a register write.
- REG_ADDR_WIDTH, 5, register address width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Reset_n  input  1  asynchronous active-low reset.
- i_Alu_Valid  input  1  ALU source offers a write.
- o_Alu_Ready  output  1  ALU FIFO can accept.
- i_Alu_Rd  input  REG_ADDR_WIDTH  ALU destination register.
- i_Alu_Data  input  XLEN  ALU write data.
- i_Lsu_Valid  input  1  LSU source offers a write.
- o_Lsu_Ready  output  1  LSU FIFO can accept.
- i_Lsu_Rd  input  REG_ADDR_WIDTH  LSU destination register.
- i_Lsu_Data  input  XLEN  LSU write data.
- o_Wr_En  output  1  register_file write enable.
- o_Wr_Addr  output  REG_ADDR_WIDTH  register_file write address.
- o_Wr_Data  output  XLEN  register_file write data.
- o_Wr_From_Lsu  output  1  current write originated from LSU (0 = ALU).

Behaviour:
- Clocking and reset: one clock, i_Clock. Reset i_Reset_n is asynchronous and active-low.
- Reset values:
  - o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0, o_Wr_From_Lsu=0.
  - Both FIFOs empty, so o_Alu_Ready=1 and o_Lsu_Ready=1 after reset deasserts.
  - Round-robin pointer = 0 (ALU favoured first).
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - ready = FIFO not full, combinational from the occupancy count only.
  - There is no pop-through: a full FIFO shows ready=0 even in a cycle when it is popped.
  - Inputs are ignored when valid=0.
- x0 filter: a transfer with Rd==0 is accepted (ready unchanged) but not stored and produces no write.
- FIFO: per source, circular buffer with read/write pointers and a count 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave the count unchanged.
- Arbitration (combinational on FIFO heads, every cycle):
  - Only ALU non-empty: grant ALU.
  - Only LSU non-empty: grant LSU.
  - Both non-empty: grant ALU if pointer=0, else LSU.
  - After a grant, pointer <= (granted source is ALU) ? 1 : 0. The pointer holds when there is no grant.
  - The granted head is popped on the same edge that loads the output register.
- Output register:
  - Each edge: o_Wr_En <= grant_valid, plus o_Wr_Addr, o_Wr_Data and o_Wr_From_Lsu from the granted head.
  - With no grant, o_Wr_En <= 0 and addr/data/source hold their last values.
  - o_Wr_En is high for exactly one cycle per stored entry.
- Latency: a transfer on the edge ending cycle t shows o_Wr_En=1 in cycle t+2 at the earliest.
- Ordering:
  - Writes from one source reach the port in acceptance order.
  - Across sources there is no ordering guarantee beyond the round-robin rule; the upstream sequencer owns RAW/WAW hazards.
- Throughput: sustained 1 write/cycle. With both sources saturated, writes alternate ALU, LSU, ALU, …
- Reset mid-operation: all FIFO contents and any pending output write are discarded immediately. Outputs take reset values asynchronously; no partial write is issued.

Optional Feature:
- Macro: WRITEBACK_ARBITER_PENDING_QUERY_EN.
- When defined, the block adds input i_Query_Rd [REG_ADDR_WIDTH] and output o_Query_Pending [1].
- o_Query_Pending is combinational. It is 1 when i_Query_Rd != 0 and that address matches any valid FIFO entry in either source, or the output register while o_Wr_En=1. This lets the sequencer stall a dependent read.
- When not defined, these ports and the comparison logic do not exist. Behaviour is otherwise identical.

Test Plan:
- ALU-only write: reset, one ALU transfer Rd=5 Data=0xDEADBEEF in cycle 3 -> o_Wr_En=1 in cycle 5 only, o_Wr_Addr=5, o_Wr_Data=0xDEADBEEF, o_Wr_From_Lsu=0.
- x0 drop: ALU transfer Rd=0 Data=0x1234 -> o_Alu_Ready stays 1, o_Wr_En never asserts, FIFO count stays 0.
- Round-robin contention: both sources push continuously (ALU data 0xA0,0xA1,…; LSU 0xB0,0xB1,…, Rd=1/2) -> port sequence is A0,B0,A1,B1,… at 1 write/cycle, per-source order preserved.
- Full backpressure: FIFO_DEPTH=2, ALU pushes 2 entries and the arbiter is held busy by LSU-preferred pointer -> o_Alu_Ready=0 while count=2; the third valid is not accepted until count<2; all writes are eventually emitted with none lost or duplicated.
- Async reset mid-flight: 2 entries queued in each FIFO, i_Reset_n pulled low between edges -> o_Wr_En=0 immediately, after release both readies=1 and no stale write appears.
- Pending query (macro defined): LSU Rd=7 queued, i_Query_Rd=7 -> o_Query_Pending=1 until the cycle after its o_Wr_En pulse, then 0. i_Query_Rd=0 -> always 0.
